// File: rtl/alu_issue.sv
// ID/EX decode-and-issue stage feeding the execute ALU, with a single-entry skid-free register.
// Optional `ALU_ISSUE_ILLEGAL_CNT_EN adds a saturating illegal-instruction counter port.
module alu_issue #(
  parameter int DATA_W = 32
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       inst_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        alu_ctrl_o,
  output logic [4:0]        rd_o,
  output logic              reg_write_o,
  output logic              illegal_o
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  ,
  output logic [CNT_W-1:0]  illegal_cnt_o
`endif
);

  typedef struct packed {
    logic [2:0]        ctrl;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [4:0]        rd;
    logic              rw;
  } id_ex_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd     = inst_i[11:7];

  logic unused_rs1_field;
  assign unused_rs1_field = ^inst_i[19:15];

  logic              legal;
  logic [2:0]        ctrl;
  logic              use_imm;
  logic [DATA_W-1:0] imm;

  always_comb begin
    legal   = 1'b0;
    ctrl    = 3'b000;
    use_imm = 1'b0;
    imm     = '0;
    unique case (opcode)
      OP_R: begin
        unique case ({funct7, funct3})
          {F7_BASE, 3'b111}: begin
            legal = 1'b1;
            ctrl  = 3'b000;
          end
          {F7_BASE, 3'b100}: begin
            legal = 1'b1;
            ctrl  = 3'b001;
          end
          {F7_BASE, 3'b001}: begin
            legal = 1'b1;
            ctrl  = 3'b010;
          end
          {F7_BASE, 3'b000}: begin
            legal = 1'b1;
            ctrl  = 3'b011;
          end
          {F7_ALT, 3'b000}: begin
            legal = 1'b1;
            ctrl  = 3'b100;
          end
          {F7_MUL, 3'b000}: begin
            legal = 1'b1;
            ctrl  = 3'b101;
          end
          default: ;
        endcase
      end
      OP_I: begin
        if (funct3 == 3'b000) begin
          legal   = 1'b1;
          ctrl    = 3'b011;
          use_imm = 1'b1;
          imm     = {{(DATA_W-12){inst_i[31]}}, inst_i[31:20]};
        end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
          legal   = 1'b1;
          ctrl    = 3'b110;
          use_imm = 1'b1;
          imm     = {{(DATA_W-5){1'b0}}, inst_i[24:20]};
        end
      end
      default: ;
    endcase
  end

  id_ex_t dec;
  always_comb begin
    dec.ctrl = ctrl;
    dec.d1   = rs1_data_i;
    dec.d2   = use_imm ? imm : rs2_data_i;
    dec.rd   = rd;
    dec.rw   = (rd != 5'd0);
  end

  logic   vld_q, vld_d;
  logic   ill_q, ill_d;
  id_ex_t ent_q, ent_d;
  logic   accept;

  assign in_ready_o = !vld_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  // Illegal encodings are consumed as a bubble; payload keeps its old value.
  always_comb begin
    vld_d = vld_q;
    ent_d = ent_q;
    ill_d = ill_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (accept) begin
      vld_d = legal;
      if (legal) ent_d = dec;
      else       ill_d = 1'b1;
    end else if (out_ready_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      ent_q <= '0;
    end else begin
      vld_q <= vld_d;
      ill_q <= ill_d;
      ent_q <= ent_d;
    end
  end

  assign out_valid_o = vld_q;
  assign data1_o     = ent_q.d1;
  assign data2_o     = ent_q.d2;
  assign alu_ctrl_o  = ent_q.ctrl;
  assign rd_o        = ent_q.rd;
  assign reg_write_o = ent_q.rw;
  assign illegal_o   = ill_q;

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !legal && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign illegal_cnt_o = cnt_q;
`endif

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode-and-issue stage that feeds the execute-stage ALU: the producing end of the ALU operand/control interface.
- Accepts one instruction per cycle with its register-file read data.
- Decodes opcode/funct3/funct7 into the 3-bit ALU control code and selects operand 2 (register or immediate).
- Holds results in a single-entry ID/EX pipeline register with a valid/ready handshake, stall and flush.

Parameters:
- DATA_W, 32, operand width; instruction width fixed at 32.
- CNT_W, 16, width of the illegal-instruction counter (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  kill the held entry and drop this cycle's input
- in_valid_i  in  1  instruction/operands valid
- in_ready_o  out  1  stage can accept
- inst_i  in  32  instruction word
- rs1_data_i  in  DATA_W  register-file read port 1
- rs2_data_i  in  DATA_W  register-file read port 2
- out_valid_o  out  1  issued entry valid
- out_ready_i  in  1  execute stage accepts
- data1_o  out  DATA_W  ALU operand 1
- data2_o  out  DATA_W  ALU operand 2
- alu_ctrl_o  out  3  ALU control code
- rd_o  out  5  destination register
- reg_write_o  out  1  entry writes rd
- illegal_o  out  1  sticky: an unsupported instruction was dropped

Behaviour:
- Reset (async, rst_i=1): out_valid_o=0; data1_o, data2_o, alu_ctrl_o, rd_o, reg_write_o=0; illegal_o=0. All registers clear immediately, not at the next edge.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - Accept occurs when in_valid_i && in_ready_o && !flush_i.
  - Latency: one cycle from accept to out_valid_o.
  - Full throughput when out_ready_i is held high.
- Stall: while out_valid_o && !out_ready_i, every output register holds its value.
- Decode (opcode inst[6:0], funct3 inst[14:12], funct7 inst[31:25]):
  - R-type 0110011, funct7 0000000: funct3 111 AND→000; 100 XOR→001; 001 SLL→010; 000 ADD→011.
  - R-type 0110011, funct7 0100000, funct3 000: SUB→100.
  - R-type 0110011, funct7 0000001, funct3 000: MUL→101.
  - I-type 0010011, funct3 000: ADDI→011; data2 = sign-extended inst[31:20].
  - I-type 0010011, funct3 101, inst[31:25]=0100000: SRAI→110; data2 = zero-extended inst[24:20].
  - R-type: data2 = rs2_data_i. All types: data1 = rs1_data_i, rd = inst[11:7], reg_write = 1.
- Illegal instruction (any other encoding):
  - Accepted and consumed, but not issued.
  - The output register loads as a bubble: out_valid_o=0 on the next cycle.
  - illegal_o sets and stays 1 until reset.
- rd = x0 on a legal instruction: still issued, with reg_write_o=0.
- Flush:
  - flush_i=1 forces out_valid_o=0 on the next edge, regardless of out_ready_i.
  - The input this cycle is not accepted.
  - Flush has priority over stall and accept.
- Simultaneous handoff: out_ready_i=1 with a new accept in the same cycle replaces the entry with no bubble.
- Held outputs (data1_o, data2_o, alu_ctrl_o, rd_o, reg_write_o) are undefined-but-stable while out_valid_o=0. They update only on accept.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_CNT_EN.
- Defined:
  - Adds output port illegal_cnt_o [CNT_W-1:0], reset to 0.
  - Increments once per dropped illegal instruction.
  - Saturates at all-ones.
  - A flush in the same cycle suppresses the increment.
- Undefined: port and counter absent; illegal_o behaviour unchanged.

Test Plan:
- Reset mid-stall, with out_valid_o=1 and out_ready_i=0: assert rst_i between edges → out_valid_o=0 immediately; after release, in_ready_o=1.
- Decode sweep: sub x3,x1,x2 with rs1=7, rs2=9 → next cycle alu_ctrl_o=100, data1_o=7, data2_o=9, rd_o=3. Repeat for AND/XOR/SLL/ADD/MUL → codes 000/001/010/011/101.
- Immediates:
  - addi x5,x1,-1 → alu_ctrl_o=011, data2_o=0xFFFFFFFF.
  - srai x6,x1,4 → alu_ctrl_o=110, data2_o=4.
- Back-pressure: out_ready_i=0 for 3 cycles with in_valid_i=1 → in_ready_o=0 and outputs stable. Raising out_ready_i → next instruction issues with no bubble.
- Illegal instruction: inst=0x0000_0063 (branch) → no issue, illegal_o=1 sticky. With ALU_ISSUE_ILLEGAL_CNT_EN, illegal_cnt_o=1.
- Flush: flush_i=1 in the same cycle as a valid add with a held entry → next cycle out_valid_o=0, input not consumed (in_ready_o was high but no issue).
